// File: rtl/instr_loader.sv
// instr_loader
//   Receives a little-endian byte stream, packs it into 32-bit instruction
//   words and writes them to consecutive word addresses of an instruction
//   memory. The CPU datapath is held in reset until a load completes.
//
// Parameters
//   ADDR_W    word-address width of the instruction memory (DEPTH = 2**ADDR_W)
//   DATA_W    instruction word width, fixed at 32 (4 bytes per word)
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle load request, honoured only in IDLE or DONE
//   num_words  number of words to load, sampled with start
//   in_valid   byte stream valid
//   in_data    byte stream data (byte 0 is the least significant)
//   in_ready   a byte is accepted this cycle when in_valid is also high
//   mem_we     one-cycle registered memory write strobe
//   mem_addr   registered word address of the write
//   mem_wdata  registered instruction word being written
//   cpu_hold   1 = datapath held in reset, 0 only once the load is done
//   busy       load in progress (RECV or WRITE)
//   done       load completed
//   error      sticky flag: a start carried num_words > DEPTH
module instr_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W:0]   nwords_q;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_inc;
    logic [1:0]        byte_cnt;
    logic [23:0]       wbuf;
    logic              accept;
    logic              start_ok;

    assign accept   = in_valid && (state == RECV);
    assign word_inc = word_cnt + WORD_ONE;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE, DONE: begin
                done     = (state == DONE);
                cpu_hold = (state != DONE);
                if (start) begin
                    if (num_words == '0) begin
                        state_next = DONE;
                    end else if (num_words > DEPTH) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (byte_cnt == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (word_inc == nwords_q) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe and its address/data are loaded on the edge that
    // accepts byte 3, so they are registered yet line up with the WRITE state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nwords_q  <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            wbuf      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                if (num_words > DEPTH) begin
                    error <= 1'b1;
                end else begin
                    error    <= 1'b0;
                    nwords_q <= num_words;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                end
            end
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: wbuf[7:0]   <= in_data;
                    2'd1: wbuf[15:8]  <= in_data;
                    2'd2: wbuf[23:16] <= in_data;
                    default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt[ADDR_W-1:0];
                        mem_wdata <= {in_data, wbuf};
                    end
                endcase
            end
            if (state == WRITE) begin
                word_cnt <= word_inc;
            end
        end
    end

endmodule
